// File: rtl/bcd_lcd_writer_if.sv
// Bus bundle for bcd_lcd_writer: binary value input stream and
// character output stream towards an LCD character interface.
//
// Handshake rule for both streams: a beat transfers on a rising clk edge
// where valid=1 and ready=1. Once valid is raised, the source holds valid
// and its data/last fields stable until that transfer happens.
interface bcd_lcd_writer_if;
    logic       bin_valid;
    logic [7:0] bin_data;
    logic       bin_ready;
    logic       char_valid;
    logic [7:0] char_data;
    logic       char_ready;
    logic       char_last;
    logic       busy;

    // Driver/consumer side (testbench or surrounding logic)
    modport master (
        output bin_valid, bin_data, char_ready,
        input  bin_ready, char_valid, char_data, char_last, busy
    );

    // Converter side
    modport slave (
        input  bin_valid, bin_data, char_ready,
        output bin_ready, char_valid, char_data, char_last, busy
    );
endinterface

// File: rtl/bcd_lcd_writer.sv
// bcd_lcd_writer: accepts an 8-bit binary value, converts it to BCD with
// the shift-and-add-3 algorithm (one bit per cycle), then streams four
// ASCII characters (thousands, hundreds, tens, ones) to an LCD writer.
// Leading zeros optionally become spaces; the ones digit never does.
module bcd_lcd_writer #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    bcd_lcd_writer_if.slave   bus,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t      state;
    logic [11:0] bcd;        // {hundreds, tens, ones}
    logic [7:0]  sh;         // binary bits still to be shifted in, MSB first
    logic [2:0]  cnt;        // conversion iteration 0..7
    logic [1:0]  idx;        // digit being presented: 0=thousands .. 3=ones
    logic        bin_ready_r;
    logic        char_valid_r;
    logic [7:0]  char_data_r;
    logic        char_last_r;
    logic        busy_r;
    logic [11:0] bcd_adj;

    assign bus.bin_ready  = bin_ready_r;
    assign bus.char_valid = char_valid_r;
    assign bus.char_data  = char_data_r;
    assign bus.char_last  = char_last_r;
    assign bus.busy       = busy_r;
    assign state_dbg      = state;

    // ASCII for digit position i; a digit is "leading" when it and every
    // digit before it are zero (thousands is always zero for 8-bit input).
    function automatic logic [7:0] digit_char(input logic [1:0] i, input logic [11:0] b);
        logic [3:0] d;
        logic       lead;
        case (i)
            2'd0: begin d = 4'd0;     lead = 1'b1;               end
            2'd1: begin d = b[11:8];  lead = (b[11:8] == 4'd0);  end
            2'd2: begin d = b[7:4];   lead = (b[11:4] == 8'd0);  end
            default: begin d = b[3:0]; lead = 1'b0;              end
        endcase
        return (BLANK_LEADING && lead) ? 8'h20 : {4'h3, d};
    endfunction

    // Add-3 correction: any nibble >= 5 would overflow past 9 when doubled
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bcd          <= 12'd0;
            sh           <= 8'd0;
            cnt          <= 3'd0;
            idx          <= 2'd0;
            bin_ready_r  <= 1'b0;
            char_valid_r <= 1'b0;
            char_data_r  <= 8'd0;
            char_last_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bin_ready_r <= 1'b1;
                    if (bus.bin_valid && bin_ready_r) begin
                        sh          <= bus.bin_data;
                        bcd         <= 12'd0;
                        cnt         <= 3'd0;
                        bin_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state       <= CONVERT;
                    end
                end
                CONVERT: begin
                    bcd <= {bcd_adj[10:0], sh[7]};
                    sh  <= {sh[6:0], 1'b0};
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        idx   <= 2'd0;
                        state <= EMIT;
                    end
                end
                EMIT: begin
                    if (!char_valid_r) begin
                        // First character: one cycle after conversion finishes
                        char_data_r  <= digit_char(idx, bcd);
                        char_last_r  <= (idx == 2'd3);
                        char_valid_r <= 1'b1;
                    end else if (bus.char_ready) begin
                        if (idx == 2'd3) begin
                            char_valid_r <= 1'b0;
                            char_last_r  <= 1'b0;
                            busy_r       <= 1'b0;
                            bin_ready_r  <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            idx         <= idx + 2'd1;
                            char_data_r <= digit_char(idx + 2'd1, bcd);
                            char_last_r <= (idx == 2'd2);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
